// File: rtl/vidgen_pkg.sv
// Shared types and constants for the video test-pattern generator.
// The LFSR constants are only consumed when VIDGEN_LFSR_EN is defined.
package vidgen_pkg;

  typedef enum logic [1:0] {
    PAT_RAMP_H  = 2'd0,
    PAT_RAMP_V  = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_CONST   = 2'd3
  } pattern_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VBLANK = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_HBLANK = 2'd3
  } state_t;

  // Internal position counters are wider than the 10-bit coordinates the patterns use.
  localparam int COORD_W     = 12;
  localparam int PIX_COORD_W = 10;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/vidgen_timing.sv
// Raster timing: pixsync divider, x/line counters and the frame FSM.
// All video flags are registered and only change on a pixsync tick.
module vidgen_timing
  import vidgen_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_ACTIVE = 480,
  parameter int V_BLANK  = 45,
  parameter int PIX_DIV  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_enable,
  output logic                   o_tick,
  output logic                   o_frame_start,
  output logic                   o_pixsync,
  output logic                   o_hblank,
  output logic                   o_vblank,
  output logic                   o_visible,
  output logic [PIX_COORD_W-1:0] o_x,
  output logic [PIX_COORD_W-1:0] o_y,
  output logic [15:0]            o_frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int DIV_W   = $clog2(PIX_DIV);

  state_t                 r_state;
  logic                   r_flush;
  logic [DIV_W-1:0]       r_div;
  logic [COORD_W-1:0]     r_x;
  logic [COORD_W-1:0]     r_line;
  logic                   r_pixsync;
  logic                   r_hblank;
  logic                   r_vblank;
  logic                   r_visible;
  logic [PIX_COORD_W-1:0] r_xo;
  logic [PIX_COORD_W-1:0] r_yo;
  logic [15:0]            r_fcount;

  logic w_div_wrap;
  logic w_running;
  logic w_tick;
  logic w_line_end;
  logic w_frame_end;

  assign w_div_wrap  = (r_div == DIV_W'(PIX_DIV - 1));
  // r_flush keeps the divider alive for one trailing pixsync after the last frame
  assign w_running   = (r_state != ST_IDLE) || r_flush;
  assign w_tick      = w_running && w_div_wrap;
  assign w_line_end  = (r_x == COORD_W'(H_TOTAL - 1));
  assign w_frame_end = w_tick && (r_state == ST_HBLANK) && w_line_end &&
                       (r_line == COORD_W'(V_ACTIVE - 1));

  assign o_tick        = w_tick;
  assign o_frame_start = ((r_state == ST_IDLE) && !r_flush && i_enable) ||
                         (w_frame_end && i_enable);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_flush   <= 1'b0;
      r_div     <= '0;
      r_x       <= '0;
      r_line    <= '0;
      r_pixsync <= 1'b0;
      r_hblank  <= 1'b0;
      r_vblank  <= 1'b1;
      r_visible <= 1'b0;
      r_xo      <= '0;
      r_yo      <= '0;
      r_fcount  <= '0;
    end else begin
      r_pixsync <= w_tick;

      if ((r_state == ST_IDLE) && !r_flush) begin
        r_div <= '0;
        if (i_enable) begin
          // Starting at 1 places the first pixsync PIX_DIV clocks after the start
          r_state <= ST_VBLANK;
          r_div   <= DIV_W'(1);
          r_x     <= '0;
          r_line  <= '0;
        end
      end else begin
        r_div <= w_div_wrap ? '0 : r_div + DIV_W'(1);
      end

      if (w_tick) begin
        r_hblank  <= (r_state != ST_IDLE) && (r_x >= COORD_W'(H_ACTIVE));
        r_vblank  <= (r_state == ST_VBLANK) || (r_state == ST_IDLE);
        r_visible <= (r_state == ST_ACTIVE);
        r_xo      <= r_x[PIX_COORD_W-1:0];
        r_yo      <= r_line[PIX_COORD_W-1:0];

        case (r_state)
          ST_IDLE: r_flush <= 1'b0;
          ST_VBLANK: begin
            if (w_line_end) begin
              r_x <= '0;
              if (r_line == COORD_W'(V_BLANK - 1)) begin
                r_line  <= '0;
                r_state <= ST_ACTIVE;
              end else begin
                r_line <= r_line + COORD_W'(1);
              end
            end else begin
              r_x <= r_x + COORD_W'(1);
            end
          end
          ST_ACTIVE: begin
            if (r_x == COORD_W'(H_ACTIVE - 1)) r_state <= ST_HBLANK;
            r_x <= r_x + COORD_W'(1);
          end
          ST_HBLANK: begin
            if (w_line_end) begin
              r_x <= '0;
              if (r_line == COORD_W'(V_ACTIVE - 1)) begin
                r_line   <= '0;
                r_fcount <= r_fcount + 16'd1;
                if (i_enable) begin
                  r_state <= ST_VBLANK;
                end else begin
                  r_state <= ST_IDLE;
                  r_flush <= 1'b1;
                end
              end else begin
                r_line  <= r_line + COORD_W'(1);
                r_state <= ST_ACTIVE;
              end
            end else begin
              r_x <= r_x + COORD_W'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_pixsync     = r_pixsync;
  assign o_hblank      = r_hblank;
  assign o_vblank      = r_vblank;
  assign o_visible     = r_visible;
  assign o_x           = r_xo;
  assign o_y           = r_yo;
  assign o_frame_count = r_fcount;

endmodule

// File: rtl/vid_pattern_gen.sv
// Video test-pattern source: raster timing plus per-frame pattern datapath.
// Define VIDGEN_LFSR_EN to make mode 3 a per-frame LFSR instead of const_value.
module vid_pattern_gen
  import vidgen_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_ACTIVE = 480,
  parameter int V_BLANK  = 45,
  parameter int PIX_DIV  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] const_value,
  output logic [15:0] vid_pixel,
  output logic        vid_pixsync,
  output logic        vid_hblank,
  output logic        vid_vblank,
  output logic        vid_visible,
  output logic [15:0] frame_count
);

  logic                   w_tick;
  logic                   w_frame_start;
  logic                   w_visible;
  logic [PIX_COORD_W-1:0] w_x;
  logic [PIX_COORD_W-1:0] w_y;
  logic [15:0]            w_mode3;
  logic [15:0]            w_pix;
  pattern_t               r_sel;
  logic [15:0]            r_pixel;

  vidgen_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_ACTIVE (V_ACTIVE),
    .V_BLANK  (V_BLANK),
    .PIX_DIV  (PIX_DIV)
  ) u_timing (
    .clk           (clk),
    .rst           (rst),
    .i_enable      (enable),
    .o_tick        (w_tick),
    .o_frame_start (w_frame_start),
    .o_pixsync     (vid_pixsync),
    .o_hblank      (vid_hblank),
    .o_vblank      (vid_vblank),
    .o_visible     (w_visible),
    .o_x           (w_x),
    .o_y           (w_y),
    .o_frame_count (frame_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel <= PAT_RAMP_H;
    end else if (w_frame_start) begin
      r_sel <= pattern_t'(pattern_sel);
    end
  end

`ifdef VIDGEN_LFSR_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_frame_start) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_tick && w_visible) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign w_mode3 = r_lfsr;
`else
  logic [15:0] r_const;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_const <= '0;
    end else if (w_frame_start) begin
      r_const <= const_value;
    end
  end

  assign w_mode3 = r_const;
`endif

  // Pattern for the position currently on the flags; it leaves on the next pixsync
  always_comb begin
    w_pix = '0;
    if (w_visible) begin
      case (r_sel)
        PAT_RAMP_H:  w_pix = {w_x, 6'd0};
        PAT_RAMP_V:  w_pix = {w_y, 6'd0};
        PAT_CHECKER: w_pix = (w_x[5] ^ w_y[5]) ? 16'hFFFF : 16'h0000;
        PAT_CONST:   w_pix = w_mode3;
        default:     w_pix = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pixel <= '0;
    end else if (w_tick) begin
      r_pixel <= w_pix;
    end
  end

  assign vid_pixel   = r_pixel;
  assign vid_visible = w_visible;

endmodule

// File: doc/vid_pattern_gen.md
VID_PATTERN_GEN -- requirements
Module: vid_pattern_gen

Interface
REQ-001 The module SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 The module SHALL have parameter H_BLANK, default 160, meaning hblank pixels per line.
REQ-003 The module SHALL have parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-004 The module SHALL have parameter V_BLANK, default 45, meaning vblank lines per frame.
REQ-005 The module SHALL have parameter PIX_DIV, default 4, meaning clocks per pixsync, minimum 2.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; all logic runs on it.
REQ-007 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 The module SHALL have port enable, input, 1 bit: run request, sampled only at frame boundaries.
REQ-009 The module SHALL have port pattern_sel, input, 2 bits: 0 RAMP_H, 1 RAMP_V, 2 CHECKER, 3 CONST/LFSR.
REQ-010 The module SHALL have port const_value, input, 16 bits: pixel value for mode 3 when LFSR is not compiled in.
REQ-011 The module SHALL have ports vid_pixel (output, 16), vid_pixsync (output, 1), vid_hblank (output, 1), vid_vblank (output, 1) and vid_visible (output, 1) forming the video source bus.
REQ-012 The module SHALL have port frame_count, output, 16 bits: count of completed frames.

Function
REQ-013 vid_pixsync SHALL pulse high for exactly 1 clk every PIX_DIV clks while running, and SHALL stay 0 while idle.
REQ-014 The hblank, vblank and visible flags SHALL change only in cycles where pixsync is high, and SHALL describe the current position.
REQ-015 vid_pixel SHALL update only in pixsync cycles and SHALL carry the pixel of the previous pixsync position, lagging the flags by one pixsync.
REQ-016 A frame SHALL consist of V_BLANK lines followed by V_ACTIVE lines; each line SHALL be H_ACTIVE positions then H_BLANK positions.
REQ-017 vblank SHALL be 1 on all positions of vblank lines; hblank SHALL be 1 on the last H_BLANK positions of every line; visible SHALL equal !hblank && !vblank.
REQ-018 On non-visible positions vid_pixel SHALL be 16'h0000.
REQ-019 Patterns SHALL use visible x (0..H_ACTIVE-1) and y (0..V_ACTIVE-1) as follows: RAMP_H = {x[9:0],6'd0}; RAMP_V = {y[9:0],6'd0}; CHECKER = (x[5]^y[5]) ? 16'hFFFF : 16'h0000; mode 3 = const_value.
REQ-020 The FSM SHALL have states IDLE, VBLANK, ACTIVE and HBLANK; IDLE->VBLANK when enable=1 at a frame boundary; VBLANK->ACTIVE after V_BLANK lines; ACTIVE<->HBLANK per line; the last HBLANK of the last line SHALL go to VBLANK if enable=1, else IDLE.
REQ-021 pattern_sel and const_value SHALL be latched at frame start; mid-frame changes SHALL take effect from the next frame only.
REQ-022 Deasserting enable mid-frame SHALL let the frame complete; frame_count SHALL increment by 1 (wrapping 16'hFFFF->0) at the end of every completed frame.
REQ-023 The final pixel of a frame SHALL be emitted on the first pixsync of the following frame, or on one trailing pixsync if entering IDLE.

Reset
REQ-024 While rst=0, outputs SHALL immediately be: vid_pixel=0, pixsync=0, hblank=0, vblank=1, visible=0, frame_count=0, and the state SHALL be IDLE.
REQ-025 After rst release with enable=1, the first pixsync SHALL occur PIX_DIV clks later; a reset mid-line SHALL abandon the frame with no frame_count increment.

Configuration
REQ-026 With macro VIDGEN_LFSR_EN defined, mode 3 SHALL output a 16-bit Fibonacci LFSR (taps 16,14,13,11) seeded 16'hACE1 at each frame start and advanced once per visible pixel; without it, mode 3 SHALL output const_value and no LFSR logic SHALL exist.

Structure
REQ-027 Package vidgen_pkg SHALL hold the pattern_t enum, the FSM state typedef and the LFSR seed/taps constants.
REQ-028 Sub-module vidgen_timing SHALL contain the pixsync divider, x/y counters and FSM; the top SHALL add the pattern datapath and the pixel delay register.

Verification
REQ-029 H_ACTIVE=8, H_BLANK=2, V_ACTIVE=4, V_BLANK=2, PIX_DIV=2, RAMP_H -> 60 pixsyncs/frame (20 vblank, 32 visible), and pixels on the pixsyncs after visible x=0,1,7 SHALL be 16'h0000, 16'h0040 and 16'h01C0.
REQ-030 Default parameters, CHECKER -> the pixel for (x=32, y=0) SHALL be 16'hFFFF and for (x=32, y=32) SHALL be 16'h0000.
REQ-031 Switching pattern_sel 0->1 mid-frame -> the current frame SHALL remain RAMP_H, the next frame SHALL be RAMP_V, and frame_count SHALL go 0->1.
REQ-032 Dropping enable at line 2 of a frame -> that frame SHALL complete, then pixsync SHALL stay 0 with vblank=1; re-raising enable SHALL start a fresh frame with vblank first.
REQ-033 Asserting rst mid-visible line -> all outputs SHALL take reset values in the same cycle, and no frame_count increment SHALL occur.
REQ-034 Mode 3 with const_value=16'h1234 -> the first visible pixel SHALL be 16'hACE1 with VIDGEN_LFSR_EN defined and 16'h1234 without it.
